// File: rtl/aurora_pkg.sv
// Shared Aurora transmit-path types and constants: ordered-set kinds,
// 64B/66B sync headers, block-type bytes, gearbox geometry and the
// scrambler helper used by tx_block_encoder.
package aurora_pkg;

    // Block kind presented by data_controller every cycle
    typedef enum logic [2:0] {
        OS_IDLE = 3'd0,
        OS_DATA = 3'd1,
        OS_CC   = 3'd2,
        OS_SEP  = 3'd3,
        OS_SEP7 = 3'd4
    } ordered_sets_e;

    // 64B/66B sync headers
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Control block-type bytes (payload byte 0) and clock-compensation flag
    localparam logic [7:0] BT_IDLE = 8'h78;
    localparam logic [7:0] BT_SEP  = 8'h1E;
    localparam logic [7:0] BT_SEP7 = 8'hE1;
    localparam logic [7:0] CC_FLAG = 8'h80;

    // Block and gearbox geometry
    localparam int BLOCK_SIZE     = 66;
    localparam int PAYLOAD_W      = 64;
    localparam int GEARBOX_PERIOD = 33;

    // Scrambler x^58 + x^39 + 1
    localparam int SCR_W   = 58;
    localparam int SCR_TAP = 39;
    localparam logic [SCR_W-1:0] SCR_INIT = 58'h3FF_FFFF_FFFF_FFFF;

    // A 66-bit block: sync header in the two LSBs, payload above it
    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [1:0]           sync;
    } block_t;

    // Scrambles one payload, bit 0 first. state[SCR_W-1] is the most recently
    // scrambled bit, so bit i looks back through a combined history where
    // the first SCR_W entries are the previous block's tail. The next state
    // is simply the top SCR_W scrambled bits of this payload.
    function automatic logic [PAYLOAD_W-1:0] scramble_payload(
        input logic [PAYLOAD_W-1:0] p,
        input logic [SCR_W-1:0]     state
    );
        logic [SCR_W+PAYLOAD_W-1:0] hist;
        hist = '0;
        hist[SCR_W-1:0] = state;
        for (int i = 0; i < PAYLOAD_W; i++) begin
            hist[SCR_W+i] = p[i] ^ hist[i+SCR_W-SCR_TAP] ^ hist[i];
        end
        return hist[SCR_W+PAYLOAD_W-1:SCR_W];
    endfunction

endpackage

// File: rtl/tx_gearbox.sv
// 66-to-64 gearbox. Owns the 0..32 sequence counter, the leftover-bit
// residue and the upstream ready. Every 33 cycles it consumes 32 blocks and
// spends the last slot draining the 64-bit residue, so the output word
// stream is continuous with bit 0 of each word transmitted first.
module tx_gearbox
    import aurora_pkg::*;
(
    input  logic                  clk_data,
    input  logic                  rst,
    input  logic [BLOCK_SIZE-1:0] blk,
    output logic                  in_ready,
    output logic [63:0]           tx_data,
    output logic                  tx_valid
);

    localparam logic [5:0] SEQ_LAST  = 6'(GEARBOX_PERIOD - 1);
    localparam logic [5:0] SEQ_STALL = 6'(GEARBOX_PERIOD - 2);

    logic [5:0]   seq;
    logic [63:0]  residue;
    logic         primed;
    logic [127:0] shifted;
    logic [63:0]  word_next;
    logic [63:0]  residue_next;

    // The block arriving at seq 32 would have nowhere to go, so upstream is
    // held off one cycle earlier; stage 1 is then empty during the drain.
    assign in_ready = (seq != SEQ_STALL);

    // Place the new block above the 2*seq residue bits; whatever spills past
    // bit 63 becomes the next residue. The last slot only drains the residue.
    always_comb begin
        shifted      = {62'b0, blk} << {seq, 1'b0};
        word_next    = shifted[63:0] | residue;
        residue_next = shifted[127:64];
        if (seq == SEQ_LAST) begin
            word_next    = residue;
            residue_next = '0;
        end
    end

    // Sequence, residue and output registers; tx_valid follows one cycle
    // behind 'primed' so the word built from the post-reset empty stage 1
    // is not flagged.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            seq      <= '0;
            residue  <= '0;
            tx_data  <= '0;
            primed   <= 1'b0;
            tx_valid <= 1'b0;
        end else begin
            seq      <= (seq == SEQ_LAST) ? 6'd0 : seq + 6'd1;
            residue  <= residue_next;
            tx_data  <= word_next;
            primed   <= 1'b1;
            tx_valid <= primed;
        end
    end

endmodule

// File: rtl/tx_block_encoder.sv
// Transmit-side 64B/66B block encoder. Turns each accepted ordered set and
// payload into a 66-bit block (sync header + block type), optionally
// scrambles the payload, registers it (stage 1) and hands it to tx_gearbox
// (stage 2), which produces the continuous 64-bit word stream.
// Build option: define AURORA_SCRAMBLER_EN to enable the x^58+x^39+1
// self-synchronous scrambler; without it the payload passes unscrambled and
// no scrambler state is built. Timing is identical either way.
module tx_block_encoder
    import aurora_pkg::*;
(
    input  logic          clk_data,
    input  logic          rst,
    input  ordered_sets_e ordered_sets,
    input  logic [63:0]   data_in,
    output logic          in_ready,
    output logic [63:0]   tx_data,
    output logic          tx_valid
);

    logic [PAYLOAD_W-1:0] payload;
    logic [PAYLOAD_W-1:0] payload_tx;
    logic [1:0]           sync;
    block_t               blk_q;

    // Map the ordered set to sync header and payload; unknown kinds are
    // sent as IDLE so the link never carries an undefined block type.
    always_comb begin
        sync    = SYNC_CTRL;
        payload = {56'b0, BT_IDLE};
        case (ordered_sets)
            OS_DATA: begin
                sync    = SYNC_DATA;
                payload = data_in;
            end
            OS_CC:   payload = {48'b0, CC_FLAG, BT_IDLE};
            OS_SEP:  payload = {data_in[63:16], data_in[7:0], BT_SEP};
            OS_SEP7: payload = {data_in[63:8], BT_SEP7};
            default: payload = {56'b0, BT_IDLE};
        endcase
    end

`ifdef AURORA_SCRAMBLER_EN
    logic [SCR_W-1:0] scr_state;

    assign payload_tx = scramble_payload(payload, scr_state);

    // Scrambler history advances only when a block is actually accepted,
    // keeping it in step with the bits that reach the gearbox.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            scr_state <= SCR_INIT;
        end else if (in_ready) begin
            scr_state <= payload_tx[PAYLOAD_W-1:PAYLOAD_W-SCR_W];
        end
    end
`else
    assign payload_tx = payload;
`endif

    // Stage 1: capture the encoded block; it is cleared by reset so the
    // gearbox's first slot after reset contributes only zeros.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            blk_q <= '0;
        end else if (in_ready) begin
            blk_q.payload <= payload_tx;
            blk_q.sync    <= sync;
        end
    end

    tx_gearbox u_gearbox (
        .clk_data (clk_data),
        .rst      (rst),
        .blk      (blk_q),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

endmodule

// File: tb/tb_tx_block_encoder.sv
// Self-checking bench for tx_block_encoder. The reference model treats the
// output as one continuous bit stream: after reset it is 66 zero bits (the
// empty stage 1) followed by every accepted block, sync bits first, each
// payload bit scrambled by s_i = p_i ^ s_(i-39) ^ s_(i-58) when
// AURORA_SCRAMBLER_EN is defined. Each tx_data word is the next 64 bits of
// that stream. Observed words are also reassembled into blocks and
// descrambled to recover what was sent.
module tb_tx_block_encoder;
    import aurora_pkg::*;

    logic          clk_data = 1'b0;
    logic          rst = 1'b1;
    ordered_sets_e ordered_sets = OS_IDLE;
    logic [63:0]   data_in = '0;
    logic          in_ready;
    logic [63:0]   tx_data;
    logic          tx_valid;

    int passed = 0;
    int total = 0;
    int failed = 0;
    int cyc = 0;
    int acc_count = 0;

    bit          stream_q[$];
    bit          tx_hist[$];
    bit          rx_hist[$];
    bit          obs_q[$];
    logic [65:0] sent_q[$];
    logic [63:0] dec_q[$];

    tx_block_encoder dut (
        .clk_data     (clk_data),
        .rst          (rst),
        .ordered_sets (ordered_sets),
        .data_in      (data_in),
        .in_ready     (in_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid)
    );

    // Free-running data clock
    always #5 clk_data = ~clk_data;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [65:0] model_encode(input ordered_sets_e os, input logic [63:0] d);
        logic [63:0] p;
        logic [1:0]  s;
        s = 2'b10;
        if (os == OS_DATA) begin
            s = 2'b01;
            p = d;
        end else if (os == OS_CC) begin
            p = 64'h8078;
        end else if (os == OS_SEP) begin
            p = {d[63:16], d[7:0], 8'h1E};
        end else if (os == OS_SEP7) begin
            p = {d[63:8], 8'hE1};
        end else begin
            p = 64'h78;
        end
        return {p, s};
    endfunction

    task automatic model_reset();
        logic [57:0] init;
        init = 58'h3FF_FFFF_FFFF_FFFF;
        stream_q.delete();
        tx_hist.delete();
        rx_hist.delete();
        obs_q.delete();
        sent_q.delete();
        dec_q.delete();
        for (int i = 0; i < 66; i++) stream_q.push_back(1'b0);
        for (int i = 0; i < 58; i++) begin
            tx_hist.push_back(init[i]);
            rx_hist.push_back(init[i]);
        end
        cyc = 0;
        acc_count = 0;
    endtask

    task automatic model_accept(input ordered_sets_e os, input logic [63:0] d);
        logic [65:0] b;
        bit s;
        b = model_encode(os, d);
        sent_q.push_back(b);
        acc_count++;
        stream_q.push_back(b[0]);
        stream_q.push_back(b[1]);
        for (int i = 0; i < 64; i++) begin
`ifdef AURORA_SCRAMBLER_EN
            s = b[2+i] ^ tx_hist[19] ^ tx_hist[0];
            tx_hist.push_back(s);
            void'(tx_hist.pop_front());
`else
            s = b[2+i];
`endif
            stream_q.push_back(s);
        end
    endtask

    task automatic decode_observed();
        while (obs_q.size() >= 66) begin
            logic [1:0]  sy;
            logic [63:0] p;
            logic [65:0] e;
            bit s;
            sy[0] = obs_q.pop_front();
            sy[1] = obs_q.pop_front();
            for (int i = 0; i < 64; i++) begin
                s = obs_q.pop_front();
`ifdef AURORA_SCRAMBLER_EN
                p[i] = s ^ rx_hist[19] ^ rx_hist[0];
                rx_hist.push_back(s);
                void'(rx_hist.pop_front());
`else
                p[i] = s;
`endif
            end
            dec_q.push_back(p);
            if (sent_q.size() > 0) e = sent_q.pop_front();
            else e = 'x;
            check_val("blk_sync", {62'b0, sy}, {62'b0, e[1:0]});
            check_val("blk_payload", p, e[65:2]);
        end
    endtask

    task automatic checkOutput();
        logic [63:0] w;
        logic exp_ready;
        logic exp_valid;
        exp_ready = ((cyc % 33) != 31);
        exp_valid = (cyc >= 2);
        check_val("in_ready", {63'b0, in_ready}, {63'b0, exp_ready});
        check_val("tx_valid", {63'b0, tx_valid}, {63'b0, exp_valid});
        w = '0;
        if (cyc > 0) begin
            if (stream_q.size() < 64) begin
                $display("[TB] FAIL stream_model underrun at cycle %0d", cyc);
                $fatal(1, "[TB] model underrun");
            end
            for (int i = 0; i < 64; i++) w[i] = stream_q.pop_front();
        end
        check_val("tx_data", tx_data, w);
        if (cyc >= 2) begin
            for (int i = 0; i < 64; i++) begin
                if (!(cyc == 2 && i < 2)) obs_q.push_back(tx_data[i]);
            end
            decode_observed();
        end
    endtask

    task automatic applyStimulus(input ordered_sets_e os, input logic [63:0] d);
        checkOutput();
        ordered_sets = os;
        data_in = d;
        if ((cyc % 33) != 31) model_accept(os, d);
        @(posedge clk_data);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        ordered_sets = OS_IDLE;
        data_in = '0;
        repeat (n) begin
            @(posedge clk_data);
            #1;
            check_val("rst_tx_data", tx_data, 64'h0);
            check_val("rst_tx_valid", {63'b0, tx_valid}, 64'h0);
            check_val("rst_in_ready", {63'b0, in_ready}, 64'h1);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic random_steps(input int n);
        repeat (n) begin
            applyStimulus(ordered_sets_e'(3'($urandom_range(7, 0))), {$urandom, $urandom});
        end
    endtask

    // Upstream holds its inputs through the stall cycle; idx is the block's
    // position in acceptance order since reset.
    task automatic send_block(input ordered_sets_e os, input logic [63:0] d, output int idx);
        while ((cyc % 33) == 31) applyStimulus(os, d);
        idx = acc_count;
        applyStimulus(os, d);
    endtask

`ifdef AURORA_SCRAMBLER_EN
    // First block after reset is DATA 0: scrambled bits 0..38 are 0, bit 39 is 1.
    // In the cycle-2 word the payload starts at bit 4.
    task automatic check_scr_start();
        check_val("scr_bits_0_38", {25'b0, tx_data[42:4]}, 64'h0);
        check_val("scr_bit_39", {63'b0, tx_data[43]}, 64'h1);
    endtask
`endif

    initial begin
        logic [63:0] dead_word;
        logic [63:0] sep_data;
        logic [63:0] tmp;
        int sep_idx;
        int sep7_idx;

        dead_word = 64'hDEADB00DDEADB00D;
        $display("[TB] tx_block_encoder bench start");
        model_reset();
        apply_reset(2);

        // Continuous IDLE over two gearbox periods
        repeat (66) applyStimulus(OS_IDLE, 64'h0);

        // DATA block gearboxed in the seq 0 slot
        apply_reset(2);
        while (cyc < 32) applyStimulus(OS_IDLE, 64'h0);
        applyStimulus(OS_DATA, dead_word);
        applyStimulus(OS_IDLE, 64'h0);
`ifndef AURORA_SCRAMBLER_EN
        check_val("data_seq0_word", tx_data, {dead_word[61:0], 2'b01});
`endif
        applyStimulus(OS_IDLE, 64'h0);
`ifndef AURORA_SCRAMBLER_EN
        check_val("data_seq0_carry", {62'b0, tx_data[1:0]}, {62'b0, dead_word[63:62]});
`endif

        // Scrambler start-up sequence 0, DEADB00D..., 0 then random traffic
        apply_reset(2);
        applyStimulus(OS_DATA, 64'h0);
        applyStimulus(OS_DATA, dead_word);
`ifdef AURORA_SCRAMBLER_EN
        check_scr_start();
`endif
        applyStimulus(OS_DATA, 64'h0);
        random_steps(90);

        // SEP with byte count 5 followed by SEP7
        sep_data = {$urandom, $urandom};
        sep_data[7:0] = 8'h05;
        send_block(OS_SEP, sep_data, sep_idx);
        send_block(OS_SEP7, {$urandom, $urandom}, sep7_idx);
        repeat (6) applyStimulus(OS_IDLE, 64'h0);
        check_val("sep_decoded", {63'b0, dec_q.size() > sep7_idx}, 64'h1);
        if (dec_q.size() > sep7_idx) begin
            tmp = dec_q[sep_idx];
            check_val("sep_type", {56'b0, tmp[7:0]}, 64'h1E);
            check_val("sep_count", {56'b0, tmp[15:8]}, 64'h05);
            tmp = dec_q[sep7_idx];
            check_val("sep7_type", {56'b0, tmp[7:0]}, 64'hE1);
        end

        // Reset pulsed mid-frame at seq 17
        while ((cyc % 33) != 17) random_steps(1);
        apply_reset(1);
        applyStimulus(OS_DATA, 64'h0);
        applyStimulus(OS_IDLE, 64'h0);
`ifdef AURORA_SCRAMBLER_EN
        check_scr_start();
`endif
        random_steps(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
